instruction_sequencer: RTL and testbench

Drives the front end of the CPU decoder: it fetches instruction words, holds the current instruction, and steps the microcode phase counter. It produces the `instruction`, `phase`, `fetch` and `exc_triggered` signals that the decoder consumes, and it reacts to the decoder's `halt`, `_wait`, `ei`, `di` outputs and to the microcode end bit. It also injects trap and interrupt pseudo-instructions and owns the interrupt-enable flag.

---
 rtl/instruction_sequencer.sv | 113 +++++++++++
 tb/tb_instruction_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches instruction words, holds the instruction register, steps the microcode phase and injects trap/irq opcodes
// Ports: clk/rst_n (sync, active-low); ifetch_req_o-style handshake ifetch_req/ifetch_valid/instr_data;
//        ucommand + halt/_wait/ei/di from the decoder; irq, exc_req requests;
//        instruction, phase, fetch, exc_triggered, int_enable, halted, sleeping to the decoder.
module instruction_sequencer #(
  parameter int          UC_END_BIT = 27,
  parameter logic [15:0] TRAP_INSN  = 16'h8000,
  parameter logic [15:0] IRQ_INSN   = 16'h8004
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifetch_req,
  input  logic        ifetch_valid,
  input  logic [15:0] instr_data,
  input  logic [27:0] ucommand,
  input  logic        halt,
  input  logic        _wait,
  input  logic        ei,
  input  logic        di,
  input  logic        irq,
  input  logic        exc_req,
  output logic [15:0] instruction,
  output logic [2:0]  phase,
  output logic        fetch,
  output logic        exc_triggered,
  output logic        int_enable,
  output logic        halted,
  output logic        sleeping
);
  typedef enum logic [1:0] {FETCH, EXEC, WAITING, HALTED} state_t;
  state_t      state_q, state_d;
  logic [15:0] insn_q, insn_d;
  logic [2:0]  phase_q, phase_d;
  logic        exc_q, exc_d, ie_q, ie_d, req_q, req_d;
  logic        uc_end, fault, take_irq, h, w;
  logic        unused_uc;
  assign unused_uc = ^ucommand;
  always_comb begin
    uc_end   = ucommand[UC_END_BIT];
    fault    = exc_req || (phase_q == 3'd7 && !uc_end);
    // req_q low in FETCH only on a first cycle where an interrupt was foreseen
    take_irq = !req_q && irq && ie_q;
    h        = halt && !exc_q;
    w        = _wait && !exc_q;
    state_d  = state_q;
    insn_d   = insn_q;
    phase_d  = phase_q;
    exc_d    = exc_q;
    ie_d     = ie_q;
    req_d    = 1'b0;
    unique case (state_q)
      FETCH: begin
        phase_d = 3'd0;
        if (take_irq) begin
          insn_d  = IRQ_INSN;
          ie_d    = 1'b0;
          exc_d   = 1'b0;
          state_d = EXEC;
        end else if (req_q && ifetch_valid) begin
          insn_d  = instr_data;
          exc_d   = 1'b0;
          state_d = EXEC;
        end else req_d = 1'b1;
      end
      EXEC: begin
        if (fault) begin
          // a fault inside a trap is a double fault
          state_d = exc_q ? HALTED : EXEC;
          insn_d  = exc_q ? insn_q : TRAP_INSN;
          exc_d   = 1'b1;
          phase_d = 3'd0;
        end else if (uc_end) begin
          ie_d    = (ei && !exc_q) ? 1'b1 : (di && !exc_q) ? 1'b0 : ie_q;
          state_d = h ? HALTED : w ? WAITING : FETCH;
          // suppress the fetch request when the interrupt will be injected instead
          req_d   = !h && !w && !(irq && ie_d);
          exc_d   = 1'b0;
          phase_d = 3'd0;
        end else phase_d = phase_q + 3'd1;
      end
      WAITING: begin
        state_d = irq ? FETCH : WAITING;
        req_d   = irq && !ie_q;
      end
      HALTED: state_d = HALTED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      insn_q  <= 16'h0000;
      phase_q <= 3'd0;
      exc_q   <= 1'b0;
      ie_q    <= 1'b0;
      req_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      phase_q <= phase_d;
      exc_q   <= exc_d;
      ie_q    <= ie_d;
      req_q   <= req_d;
    end
  end
  assign ifetch_req    = req_q;
  assign instruction   = insn_q;
  assign phase         = phase_q;
  assign fetch         = state_q == FETCH;
  assign exc_triggered = exc_q;
  assign int_enable    = ie_q;
  assign halted        = state_q == HALTED;
  assign sleeping      = state_q == WAITING;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: scoreboard bench with directed test-plan sequences followed by random stimulus
module tb_instruction_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, ifetch_valid = 1'b0;
  logic        halt = 1'b0, _wait = 1'b0, ei = 1'b0, di = 1'b0, irq = 1'b0, exc_req = 1'b0;
  logic [15:0] instr_data = 16'h0;
  logic [27:0] ucommand = 28'h0;
  logic        ifetch_req, fetch, exc_triggered, int_enable, halted, sleeping;
  logic [15:0] instruction;
  logic [2:0]  phase;
  always #5 clk = ~clk;
  instruction_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ifetch_req(ifetch_req), .ifetch_valid(ifetch_valid),
    .instr_data(instr_data), .ucommand(ucommand), .halt(halt), ._wait(_wait), .ei(ei), .di(di),
    .irq(irq), .exc_req(exc_req), .instruction(instruction), .phase(phase), .fetch(fetch),
    .exc_triggered(exc_triggered), .int_enable(int_enable), .halted(halted), .sleeping(sleeping)
  );
  typedef struct packed {
    logic [15:0] insn;
    logic [2:0]  ph;
    logic        f, req, exc, ie, hlt, slp;
  } obs_t;
  obs_t expq[$];
  int compared = 0, mismatched = 0;
  localparam int S_FETCH = 0, S_EXEC = 1, S_WAIT = 2, S_HALT = 3;
  int          m_st = S_FETCH;
  logic [15:0] m_insn = 16'h0;
  logic [2:0]  m_ph = 3'd0;
  logic        m_exc = 1'b0, m_ie = 1'b0, m_first = 1'b1, m_req = 1'b1;
  // Reference: advances the architectural view by one clock using the inputs being driven now,
  // then queues the outputs the decoder must see after that clock.
  task automatic step();
    obs_t o;
    logic endb;
    endb = ucommand[27];
    if (!rst_n) begin
      m_st = S_FETCH; m_insn = 16'h0; m_ph = 3'd0; m_exc = 1'b0; m_ie = 1'b0; m_first = 1'b1; m_req = 1'b1;
    end else if (m_st == S_FETCH) begin
      if (m_first && irq && m_ie) begin
        m_insn = 16'h8004; m_ie = 1'b0; m_exc = 1'b0; m_ph = 3'd0; m_st = S_EXEC; m_req = 1'b0;
      end else if (m_req && ifetch_valid) begin
        m_insn = instr_data; m_exc = 1'b0; m_ph = 3'd0; m_st = S_EXEC; m_req = 1'b0;
      end else begin
        m_first = 1'b0; m_req = 1'b1;
      end
    end else if (m_st == S_EXEC) begin
      if (exc_req || (m_ph == 3'd7 && !endb)) begin
        if (m_exc) m_st = S_HALT;
        else begin m_insn = 16'h8000; m_exc = 1'b1; end
        m_ph = 3'd0;
      end else if (endb) begin
        if (ei) m_ie = 1'b1;
        else if (di) m_ie = 1'b0;
        m_ph = 3'd0; m_exc = 1'b0;
        m_st = halt ? S_HALT : _wait ? S_WAIT : S_FETCH;
        if (m_st == S_FETCH) begin m_first = 1'b1; m_req = !(irq && m_ie); end
      end else m_ph = m_ph + 3'd1;
    end else if (m_st == S_WAIT && irq) begin
      m_st = S_FETCH; m_first = 1'b1; m_req = !m_ie;
    end
    o.insn = m_insn; o.ph = m_ph; o.f = m_st == S_FETCH; o.req = m_st == S_FETCH && m_req;
    o.exc = m_exc; o.ie = m_ie; o.hlt = m_st == S_HALT; o.slp = m_st == S_WAIT;
    expq.push_back(o);
  endtask
  task automatic d(input logic r, v, input logic [15:0] dat, input logic e, hh, ww, eii, dii, iq, ex);
    @(negedge clk);
    rst_n = r; ifetch_valid = v; instr_data = dat; ucommand = {e, 27'($urandom)};
    halt = hh; _wait = ww; ei = eii; di = dii; irq = iq; exc_req = ex;
    step();
  endtask
  initial begin
    obs_t ex, got;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        ex = expq.pop_front();
        got = {instruction, phase, fetch, ifetch_req, exc_triggered, int_enable, halted, sleeping};
        compared++;
        if (got !== ex) begin
          mismatched++;
          $display("FAIL outputs t=%0t got insn=%h ph=%0d fetch=%b req=%b exc=%b ie=%b halted=%b sleep=%b / expected insn=%h ph=%0d fetch=%b req=%b exc=%b ie=%b halted=%b sleep=%b",
                   $time, got.insn, got.ph, got.f, got.req, got.exc, got.ie, got.hlt, got.slp,
                   ex.insn, ex.ph, ex.f, ex.req, ex.exc, ex.ie, ex.hlt, ex.slp);
        end
      end
    end
  end
  initial begin
    logic e;
    int   halt_cnt;
    halt_cnt = 0;
    repeat (2) d(0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 1, 16'h4A13, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 1, 0, 0, 0, 0, 0, 0);
    d(1, 1, 16'h1234, 0, 0, 0, 0, 0, 1, 0);
    d(1, 0, 16'h0, 1, 0, 0, 1, 0, 1, 0);
    d(1, 1, 16'hBEEF, 0, 0, 0, 0, 0, 1, 0);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 1, 0, 0, 1, 0, 0, 0);
    d(1, 1, 16'h2222, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 0, 0, 0, 1, 0, 0, 1);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 1, 0, 0, 0, 0, 0, 0);
    d(1, 1, 16'h3333, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) d(1, 0, 16'h0, 0, 0, 0, 0, 0, 1, 0);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 1, 1);
    d(0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 1, 16'h4444, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 1, 0, 1, 0, 0, 0, 0);
    repeat (3) d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 1, 0);
    d(1, 1, 16'h5555, 0, 0, 0, 0, 0, 1, 0);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 1, 1, 0, 0, 0, 0, 0);
    repeat (20) d(1, 0, 16'h0, 0, 0, 0, 0, 0, 1, 0);
    d(0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 1, 16'h6666, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 1, 1, 0, 0, 0, 0, 1);
    repeat (3) d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    // irq only moves where it cannot straddle an END-to-FETCH boundary
    repeat (3000) begin
      @(negedge clk);
      rst_n = !($urandom_range(0, 299) == 0 || halt_cnt > 25);
      e = m_st == S_EXEC && $urandom_range(0, 3) == 0;
      ucommand = {e, 27'($urandom)};
      ifetch_valid = 1'($urandom_range(0, 1));
      instr_data = 16'($urandom);
      exc_req = $urandom_range(0, 15) == 0;
      if (!m_exc) begin
        halt = $urandom_range(0, 15) == 0;
        _wait = $urandom_range(0, 7) == 0;
        ei = $urandom_range(0, 3) == 0;
        di = !ei && $urandom_range(0, 3) == 0;
      end else {halt, _wait, ei, di} = 4'b0;
      if (rst_n && ((m_st == S_EXEC && !e) || m_st == S_WAIT || m_st == S_HALT))
        irq = $urandom_range(0, 2) == 0;
      halt_cnt = m_st == S_HALT ? halt_cnt + 1 : 0;
      step();
    end
    @(negedge clk);
    @(negedge clk);
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected observations left, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
